// File: rtl/led_pattern_sequencer.sv
`timescale 1ns/1ps
// LED pattern sequencer: debounces four active-low keys and steps a
// chase/bounce/counter/fill pattern once per prescaler period.
module led_pattern_sequencer #(
  parameter int NUM_LEDS        = 26,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BASE_TICK       = 65536
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [3:0]          key_export,
  output logic [NUM_LEDS-1:0] leds_new_signal,
  output logic [1:0]          mode,
  output logic [2:0]          speed,
  output logic                running
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Wide enough for BASE_TICK << 7 minus one.
  localparam int PW = $clog2(BASE_TICK) + 8;

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] press;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= key_export;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      logic [CW-1:0] cnt_reg;
      logic          stable_reg;
      logic          differ;
      logic          accept;

      assign differ = (sync2_reg[gi] != stable_reg);
      assign accept = differ && (cnt_reg == CW'(DEBOUNCE_CYCLES - 1));

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b1;
        end else if (accept) begin
          cnt_reg    <= '0;
          stable_reg <= sync2_reg[gi];
        end else if (differ) begin
          cnt_reg    <= cnt_reg + CW'(1);
        end else begin
          cnt_reg    <= '0;
        end
      end

      // Only a released-to-pressed acceptance counts as an event.
      assign press[gi] = accept && stable_reg;
    end
  endgenerate

  logic [NUM_LEDS-1:0] leds_reg, leds_next;
  logic [1:0]          mode_reg, mode_next;
  logic [2:0]          speed_reg, speed_next;
  logic                running_reg, running_next;
  logic                dir_up_reg, dir_up_next;
  logic [PW-1:0]       presc_reg, presc_next;

  logic [PW-1:0]       period;
  logic                tick;
  logic [NUM_LEDS-1:0] step_pattern;
  logic                step_dir_up;

  assign period = PW'(BASE_TICK) << (3'd7 - speed_reg);
  assign tick   = running_reg && (presc_reg == period - PW'(1));

  always_comb begin
    step_pattern = leds_reg;
    step_dir_up  = dir_up_reg;
    case (mode_reg)
      2'd0: step_pattern = {leds_reg[NUM_LEDS-2:0], leds_reg[NUM_LEDS-1]};
      2'd1: begin
        if (dir_up_reg) begin
          if (leds_reg[NUM_LEDS-1]) begin
            step_pattern = leds_reg >> 1;
            step_dir_up  = 1'b0;
          end else begin
            step_pattern = leds_reg << 1;
          end
        end else begin
          if (leds_reg[0]) begin
            step_pattern = leds_reg << 1;
            step_dir_up  = 1'b1;
          end else begin
            step_pattern = leds_reg >> 1;
          end
        end
      end
      2'd2: step_pattern = leds_reg + NUM_LEDS'(1);
      default: begin
        if (&leds_reg) step_pattern = '0;
        else           step_pattern = {leds_reg[NUM_LEDS-2:0], 1'b1};
      end
    endcase
  end

  always_comb begin
    leds_next    = leds_reg;
    mode_next    = mode_reg;
    speed_next   = speed_reg;
    running_next = running_reg;
    dir_up_next  = dir_up_reg;
    presc_next   = presc_reg;

    if (running_reg) begin
      if (tick) begin
        presc_next  = '0;
        leds_next   = step_pattern;
        dir_up_next = step_dir_up;
      end else begin
        presc_next  = presc_reg + PW'(1);
      end
    end

    if (press[0]) running_next = !running_reg;

    // Opposing speed keys on the same edge cancel out entirely.
    if (press[2] && !press[3]) begin
      if (speed_reg != 3'd7) speed_next = speed_reg + 3'd1;
      presc_next = '0;
    end else if (press[3] && !press[2]) begin
      if (speed_reg != 3'd0) speed_next = speed_reg - 3'd1;
      presc_next = '0;
    end

    if (press[1]) begin
      mode_next   = mode_reg + 2'd1;
      leds_next   = mode_next[1] ? '0 : NUM_LEDS'(1);
      dir_up_next = 1'b1;
      presc_next  = '0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      leds_reg    <= NUM_LEDS'(1);
      mode_reg    <= 2'd0;
      speed_reg   <= 3'd4;
      running_reg <= 1'b1;
      dir_up_reg  <= 1'b1;
      presc_reg   <= '0;
    end else begin
      leds_reg    <= leds_next;
      mode_reg    <= mode_next;
      speed_reg   <= speed_next;
      running_reg <= running_next;
      dir_up_reg  <= dir_up_next;
      presc_reg   <= presc_next;
    end
  end

  assign leds_new_signal = leds_reg;
  assign mode            = mode_reg;
  assign speed           = speed_reg;
  assign running         = running_reg;

endmodule
